cpu_bus_dma_ctrl: RTL and testbench

Bus-side companion to the 6502 core wrapper. It generates the core clock-enable from the fast system clock and synchronises the NMI/IRQ inputs into the core's active-low pins. It passes core bus cycles through to the system bus and runs a sprite (OAM) DMA engine that halts the core through RDY. It sits between the core instance and the NES system bus/address decoder.

---
 rtl/cpu_bus_dma_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_bus_dma_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_dma_ctrl.sv
// Bus-side companion to the 6502 core: CPU clock-enable divider, NMI/IRQ
// synchronisers, core-to-system-bus pass-through and the sprite (OAM) DMA engine.
module cpu_bus_dma_ctrl #(
    parameter int          CLK_DIV     = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DMA_REG     = 16'h4014,
    parameter logic [15:0] DMA_DEST    = 16'h2004,
    parameter int          DMA_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cpu_ce,
    input  logic [15:0] core_addr,
    input  logic [7:0]  core_dout,
    input  logic        core_ren,
    input  logic        core_wen,
    output logic [7:0]  core_din,
    output logic        core_rdy,
    output logic        core_nmi_n,
    output logic        core_irq_n,
    input  logic        nmi_in,
    input  logic        irq_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic        bus_rdy,
    output logic        dma_active
);
    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CE_LAST  = CW'(CLK_DIV - 1);
    localparam logic [8:0]    LAST_IDX = 9'(DMA_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    logic [CW-1:0]          r_count;
    logic                   r_parity;
    state_t                 r_state;
    state_t                 w_nextState;
    logic [7:0]             r_page;
    logic [7:0]             r_data;
    logic [8:0]             r_index;
    logic [SYNC_STAGES-1:0] r_nmiSync;
    logic [SYNC_STAGES-1:0] r_irqSync;
    logic                   w_step;
    logic                   w_trigger;
    logic                   w_lastByte;

    assign cpu_ce     = (r_count == CE_LAST);
    assign w_step     = cpu_ce & bus_rdy;
    assign w_trigger  = w_step & core_wen & (core_addr == DMA_REG);
    assign w_lastByte = (r_index == LAST_IDX);
    assign core_din   = bus_din;
    assign core_nmi_n = ~r_nmiSync[SYNC_STAGES-1];
    assign core_irq_n = ~r_irqSync[SYNC_STAGES-1];
    assign dma_active = (r_state != IDLE);

    // Parity counts CPU cycles since reset: 0 = get cycle, 1 = put cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_parity <= 1'b0;
        end else begin
            if (cpu_ce) begin
                r_count  <= '0;
                r_parity <= ~r_parity;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmiSync <= '0;
            r_irqSync <= '0;
        end else begin
            r_nmiSync[0] <= nmi_in;
            r_irqSync[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_nmiSync[i] <= r_nmiSync[i-1];
                r_irqSync[i] <= r_irqSync[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_page  <= '0;
            r_data  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_trigger) begin
                r_page <= core_dout;
            end
            if (r_state == READ && w_step) begin
                r_data <= bus_din;
            end
            if (r_state == WRITE && w_step) begin
                r_index <= w_lastByte ? 9'd0 : r_index + 9'd1;
            end
        end
    end

    // Outside IDLE the core is parked on RDY and its strobes never reach the bus.
    always_comb begin
        w_nextState = r_state;
        bus_addr    = {r_page, r_index[7:0]};
        bus_dout    = r_data;
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        core_rdy    = 1'b0;
        case (r_state)
            IDLE: begin
                bus_addr = core_addr;
                bus_dout = core_dout;
                bus_ren  = core_ren;
                bus_wen  = core_wen;
                core_rdy = bus_rdy;
                if (w_trigger) w_nextState = HALT;
            end
            HALT: begin
                if (w_step) w_nextState = r_parity ? READ : ALIGN;
            end
            ALIGN: begin
                if (w_step) w_nextState = READ;
            end
            READ: begin
                bus_ren = 1'b1;
                if (w_step) w_nextState = WRITE;
            end
            WRITE: begin
                bus_addr = DMA_DEST;
                bus_wen  = 1'b1;
                if (w_step) w_nextState = w_lastByte ? IDLE : READ;
            end
            default: w_nextState = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_bus_dma_ctrl.sv
// Directed bench for cpu_bus_dma_ctrl: vector table for pass-through, hand
// sequences for divider, synchronisers, DMA timing, stalls and mid-DMA reset.
module tb_cpu_bus_dma_ctrl;
    localparam int          CLK_DIV  = 12;
    localparam int          DMA_LEN  = 256;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] DMA_DEST = 16'h2004;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic [15:0] core_addr;
    logic [7:0]  core_dout;
    logic        core_ren;
    logic        core_wen;
    logic [7:0]  core_din;
    logic        core_rdy;
    logic        core_nmi_n;
    logic        core_irq_n;
    logic        nmi_in;
    logic        irq_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_ren;
    logic        bus_wen;
    logic        bus_rdy;
    logic        dma_active;

    logic        memMode;
    logic [7:0]  tbBusDin;
    int          checks = 0;
    int          errors = 0;
    int          tbTick;
    bit          aborted;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        ren;
        logic        wen;
        logic [7:0]  din;
        logic        rdy;
        logic [15:0] eAddr;
        logic [7:0]  eDout;
        logic        eRen;
        logic        eWen;
        logic [7:0]  eDin;
        logic        eRdy;
    } vec_t;

    vec_t vecs[6];

    cpu_bus_dma_ctrl #(
        .CLK_DIV(CLK_DIV), .SYNC_STAGES(2), .DMA_REG(DMA_REG),
        .DMA_DEST(DMA_DEST), .DMA_LEN(DMA_LEN)
    ) dut (
        .clk(clk), .rst(rst), .cpu_ce(cpu_ce),
        .core_addr(core_addr), .core_dout(core_dout), .core_ren(core_ren),
        .core_wen(core_wen), .core_din(core_din), .core_rdy(core_rdy),
        .core_nmi_n(core_nmi_n), .core_irq_n(core_irq_n),
        .nmi_in(nmi_in), .irq_in(irq_in),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rdy(bus_rdy),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Independent timebase: clocks since reset release drive the expected divider and parity.
    always @(posedge clk or posedge rst) begin
        if (rst) tbTick <= 0;
        else     tbTick <= tbTick + 1;
    end

    function automatic bit modelCe();
        return (tbTick % CLK_DIV) == CLK_DIV - 1;
    endfunction

    function automatic bit modelPar();
        return ((tbTick / CLK_DIV) % 2) == 1;
    endfunction

    function automatic logic [7:0] memByte(input logic [15:0] a);
        return (a[7:0] ^ 8'h3C) + a[15:8];
    endfunction

    assign bus_din = memMode ? memByte(bus_addr) : tbBusDin;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        core_addr = v.addr;
        core_dout = v.dout;
        core_ren  = v.ren;
        core_wen  = v.wen;
        tbBusDin  = v.din;
        bus_rdy   = v.rdy;
    endtask

    task automatic idleInputs();
        core_addr = 16'h0000;
        core_dout = 8'h00;
        core_ren  = 1'b0;
        core_wen  = 1'b0;
        bus_rdy   = 1'b1;
    endtask

    task automatic runDma(input logic [7:0] page, input bit wantPar, input int stallIdx,
                          input int abortIdx, input int expCycles, input bit holdCore,
                          input string name, output bit abortedOut);
        int         cycles, reads, writes, beatErr, rdyErr, stallLeft, lastCeT, tEnd;
        bit         found, stalled, pending;
        logic [8:0] expIdx;
        logic [7:0] expData;
        cycles = 0; reads = 0; writes = 0; beatErr = 0; rdyErr = 0;
        stallLeft = 0; lastCeT = 0; tEnd = 0;
        found = 0; stalled = 0; pending = 0; expIdx = '0; expData = '0;
        abortedOut = 0;
        memMode = 1'b1;
        idleInputs();
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (modelCe() && (modelPar() == wantPar)) begin
                found = 1;
                break;
            end
        end
        checkOutput({name, "_parityWait"}, found, 1);
        if (!found) return;
        core_addr = DMA_REG;
        core_dout = page;
        core_wen  = 1'b1;
        #1;
        checkOutput({name, "_fwdWen"}, bus_wen, 1);
        checkOutput({name, "_fwdAddr"}, bus_addr, DMA_REG);
        @(negedge clk);
        idleInputs();
        checkOutput({name, "_activeNext"}, dma_active, 1);
        checkOutput({name, "_rdyLowNext"}, core_rdy, 0);
        if (holdCore) begin
            core_addr = DMA_REG;
            core_dout = 8'h77;
            core_wen  = 1'b1;
            core_ren  = 1'b1;
        end
        for (int t = 0; t < CLK_DIV * 700; t++) begin
            tEnd = t;
            if (dma_active !== 1'b1) break;
            if (abortIdx >= 0 && bus_ren === 1'b1 && expIdx == abortIdx) begin
                abortedOut = 1;
                break;
            end
            if (core_rdy !== 1'b0) rdyErr++;
            if (stallIdx >= 0 && !stalled && bus_ren === 1'b1 && expIdx == stallIdx) begin
                stallLeft = 3;
                stalled   = 1;
            end
            bus_rdy = (stallLeft > 0) ? 1'b0 : 1'b1;
            #1;
            if (bus_ren === 1'b1 && bus_wen === 1'b1) beatErr++;
            if (bus_wen === 1'b1 && bus_addr !== DMA_DEST) beatErr++;
            if (bus_ren === 1'b1 && bus_addr !== {page, expIdx[7:0]}) beatErr++;
            if (modelCe()) begin
                cycles++;
                lastCeT = t;
                if (bus_rdy) begin
                    if (bus_ren === 1'b1) begin
                        reads++;
                        pending = 1;
                        expData = memByte({page, expIdx[7:0]});
                    end
                    if (bus_wen === 1'b1) begin
                        writes++;
                        if (!pending || bus_dout !== expData) beatErr++;
                        pending = 0;
                        expIdx  = expIdx + 9'd1;
                    end
                end else begin
                    stallLeft--;
                end
            end
            @(negedge clk);
        end
        idleInputs();
        if (abortedOut) return;
        checkOutput({name, "_finished"}, dma_active, 0);
        checkOutput({name, "_cpuCycles"}, cycles, expCycles);
        checkOutput({name, "_reads"}, reads, DMA_LEN);
        checkOutput({name, "_writes"}, writes, DMA_LEN);
        checkOutput({name, "_beatErrors"}, beatErr, 0);
        checkOutput({name, "_rdyHeldLow"}, rdyErr, 0);
        checkOutput({name, "_releaseClk"}, tEnd - lastCeT, 1);
        #1;
        checkOutput({name, "_rdyBack"}, core_rdy, 1);
        checkOutput({name, "_strobesBack"}, {bus_ren, bus_wen}, 2'b00);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 8'hAB, 1'b1, 1'b0, 8'h5C, 1'b1, 16'h1234, 8'hAB, 1'b1, 1'b0, 8'h5C, 1'b1};
        vecs[1] = '{16'h8000, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{16'h4014, 8'h02, 1'b0, 1'b1, 8'h11, 1'b1, 16'h4014, 8'h02, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[3] = '{16'hFFFF, 8'h7E, 1'b1, 1'b0, 8'h80, 1'b0, 16'hFFFF, 8'h7E, 1'b1, 1'b0, 8'h80, 1'b0};
        vecs[4] = '{16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{16'h2004, 8'hC3, 1'b0, 1'b1, 8'h3A, 1'b1, 16'h2004, 8'hC3, 1'b0, 1'b1, 8'h3A, 1'b1};

        rst = 1'b1; nmi_in = 1'b0; irq_in = 1'b0;
        memMode = 1'b0; tbBusDin = 8'h00;
        idleInputs();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_cpuCe", cpu_ce, 0);
        checkOutput("rst_dmaActive", dma_active, 0);
        checkOutput("rst_nmiN", core_nmi_n, 1);
        checkOutput("rst_irqN", core_irq_n, 1);
        checkOutput("rst_coreRdy", core_rdy, 1);

        // Divider: first pulse 11 clocks after release, then every 12
        rst = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            checkOutput($sformatf("div_ce_clk%0d", k), cpu_ce, (k % CLK_DIV) == CLK_DIV - 1);
        end

        // Pass-through vectors, applied away from cpu_ce so the $4014 write cannot trigger
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (modelCe()) @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_busAddr", i), bus_addr, vecs[i].eAddr);
            checkOutput($sformatf("vec%0d_busDout", i), bus_dout, vecs[i].eDout);
            checkOutput($sformatf("vec%0d_busRen", i), bus_ren, vecs[i].eRen);
            checkOutput($sformatf("vec%0d_busWen", i), bus_wen, vecs[i].eWen);
            checkOutput($sformatf("vec%0d_coreDin", i), core_din, vecs[i].eDin);
            checkOutput($sformatf("vec%0d_coreRdy", i), core_rdy, vecs[i].eRdy);
            #1;
            idleInputs();
        end
        @(negedge clk);
        checkOutput("vec_noTrigger", dma_active, 0);

        // One-clock NMI pulse shows up two clocks later for exactly one clock
        nmi_in = 1'b1;
        @(negedge clk);
        nmi_in = 1'b0;
        checkOutput("nmi_lat1", core_nmi_n, 1);
        @(negedge clk);
        checkOutput("nmi_lat2", core_nmi_n, 0);
        @(negedge clk);
        checkOutput("nmi_after", core_nmi_n, 1);

        irq_in = 1'b1;
        @(negedge clk);
        checkOutput("irq_lat1", core_irq_n, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("irq_held%0d", k), core_irq_n, 0);
        end
        irq_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("irq_release", core_irq_n, 1);

        // DMA timing, alignment, stall and page-boundary cases
        runDma(8'h02, 1'b0, -1, -1, 513, 1'b1, "dmaPut", aborted);
        runDma(8'h02, 1'b1, -1, -1, 514, 1'b0, "dmaAlign", aborted);
        runDma(8'h02, 1'b0, 5, -1, 516, 1'b0, "dmaStall", aborted);
        runDma(8'hFF, 1'b0, -1, -1, 513, 1'b0, "dmaPageFF", aborted);

        // Reset during READ of index 100 aborts; a fresh trigger restarts at index 0
        runDma(8'h02, 1'b0, -1, 100, 0, 1'b0, "dmaAbort", aborted);
        checkOutput("abort_reached", aborted, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_dmaInactive", dma_active, 0);
        checkOutput("abort_coreRdy", core_rdy, 1);
        checkOutput("abort_busRen", bus_ren, 0);
        @(negedge clk);
        rst = 1'b0;
        core_ren  = 1'b1;
        core_addr = 16'h1357;
        @(negedge clk);
        checkOutput("postRst_busRen", bus_ren, 1);
        checkOutput("postRst_busAddr", bus_addr, 16'h1357);
        checkOutput("postRst_coreRdy", core_rdy, 1);
        idleInputs();
        runDma(8'h03, 1'b0, -1, -1, 513, 1'b0, "dmaRestart", aborted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
